// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage controller driving the PC register next-address/stall and pipeline flushes.
// Latency: combinational outputs from state and inputs; a redirect applies in the same cycle when imem is ready.
// Backpressure: imem_ready_i low holds the PC. A redirect seen while imem is not ready is buffered until ready.
// Optional build macro PC_SEQ_MISALIGN_TRAP_EN: misaligned redirect targets are replaced by TRAP_VECTOR.
module pc_sequencer #(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              INSTR_BYTES  = 4,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(64'h100)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [XLEN-1:0] pc_current_i,
  input  logic            hazard_stall_i,
  input  logic            imem_ready_i,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] br_target_i,
  output logic [XLEN-1:0] pc_next_o,
  output logic            pc_stall_o,
  output logic            fetch_req_o,
  output logic            if_id_flush_o,
  output logic            id_ex_flush_o,
  output logic            misalign_trap_o
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pend_target_q, pend_target_d;
  logic            pend_load;     // capture br_target_i into the pending slot this cycle
  logic            redir_br;      // apply the live EX redirect this cycle
  logic            redir_pend;    // apply the buffered redirect this cycle

  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] br_dest;
  logic [XLEN-1:0] pend_dest;
  logic            br_trap;
  logic            pend_trap;

  // Sequential fetch address; wraps modulo 2^XLEN by design.
  assign seq_pc = pc_current_i + XLEN'(INSTR_BYTES);

`ifdef PC_SEQ_MISALIGN_TRAP_EN
  logic pend_trap_q, pend_trap_d;

  // Misaligned targets are steered to the trap vector; the decision travels with a buffered target.
  assign br_trap   = |br_target_i[1:0];
  assign br_dest   = br_trap ? TRAP_VECTOR : br_target_i;
  assign pend_trap = pend_trap_q;
  assign pend_dest = pend_trap_q ? TRAP_VECTOR : pend_target_q;

  // Trap flag is captured alongside the pending target.
  always_comb begin
    pend_trap_d = pend_trap_q;
    if (pend_load) begin
      pend_trap_d = br_trap;
    end
  end

  // Pending trap flag register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_trap_q <= 1'b0;
    end else begin
      pend_trap_q <= pend_trap_d;
    end
  end
`else
  // Trap vector is only meaningful when the misalignment trap is built in.
  logic unused_trap_vector;
  assign unused_trap_vector = ^TRAP_VECTOR;

  assign br_trap   = 1'b0;
  assign br_dest   = br_target_i;
  assign pend_trap = 1'b0;
  assign pend_dest = pend_target_q;
`endif

  // Next-state selection and output decode for BOOT / RUN / PEND.
  always_comb begin
    state_d       = state_q;
    pend_load     = 1'b0;
    redir_br      = 1'b0;
    redir_pend    = 1'b0;
    pc_next_o     = pc_current_i;
    pc_stall_o    = 1'b1;
    fetch_req_o   = 1'b0;
    if_id_flush_o = 1'b0;
    id_ex_flush_o = 1'b0;

    case (state_q)
      ST_BOOT: begin
        // Load the reset vector and squash whatever is in flight.
        pc_next_o     = RESET_VECTOR;
        pc_stall_o    = 1'b0;
        if_id_flush_o = 1'b1;
        id_ex_flush_o = 1'b1;
        state_d       = ST_RUN;
      end

      ST_RUN: begin
        fetch_req_o = 1'b1;
        if (br_taken_i && imem_ready_i) begin
          // Redirect wins over a load-use stall: the stalled instruction is squashed anyway.
          redir_br      = 1'b1;
          pc_next_o     = br_dest;
          pc_stall_o    = 1'b0;
          if_id_flush_o = 1'b1;
          id_ex_flush_o = 1'b1;
        end else if (br_taken_i) begin
          pend_load     = 1'b1;
          pc_stall_o    = 1'b1;
          if_id_flush_o = 1'b1;
          id_ex_flush_o = 1'b1;
          state_d       = ST_PEND;
        end else if (hazard_stall_i || !imem_ready_i) begin
          pc_next_o  = pc_current_i;
          pc_stall_o = 1'b1;
        end else begin
          pc_next_o  = seq_pc;
          pc_stall_o = 1'b0;
        end
      end

      ST_PEND: begin
        // Keep IF/ID squashed until the buffered redirect lands; hazards are irrelevant here.
        fetch_req_o   = 1'b1;
        if_id_flush_o = 1'b1;
        pc_stall_o    = 1'b1;
        if (imem_ready_i) begin
          pc_stall_o = 1'b0;
          state_d    = ST_RUN;
          if (br_taken_i) begin
            redir_br  = 1'b1;
            pc_next_o = br_dest;
          end else begin
            redir_pend = 1'b1;
            pc_next_o  = pend_dest;
          end
        end else if (br_taken_i) begin
          // Youngest redirect replaces the buffered one.
          pend_load = 1'b1;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase

    // While reset is held everything is quiet and the vector is presented.
    if (!rst_ni) begin
      pc_next_o     = RESET_VECTOR;
      pc_stall_o    = 1'b0;
      fetch_req_o   = 1'b0;
      if_id_flush_o = 1'b0;
      id_ex_flush_o = 1'b0;
    end
  end

  // Trap pulse marks the cycle a misaligned redirect is actually applied.
  always_comb begin
    misalign_trap_o = 1'b0;
    if (rst_ni) begin
      misalign_trap_o = (redir_br && br_trap) || (redir_pend && pend_trap);
    end
  end

  // Pending target capture.
  always_comb begin
    pend_target_d = pend_target_q;
    if (pend_load) begin
      pend_target_d = br_target_i;
    end
  end

  // State and pending-target registers; reset drops any buffered redirect.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_BOOT;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      pend_target_q <= pend_target_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed start-up/redirect/reset sequence followed by random traffic.
// A PC register and a rule-level reference model live in the bench.
module tb_pc_sequencer;

  localparam logic [63:0] RV   = 64'h0;
  localparam logic [63:0] TRAP = 64'h100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] pc_cur = RV;
  logic        hs = 1'b0, rdy = 1'b1, bt = 1'b0;
  logic [63:0] tgt = '0;
  logic [63:0] pc_next;
  logic        pc_stall, fetch_req, f_ifid, f_idex, trap;

  int n_chk = 0, n_pass = 0, n_fail = 0;

  // Reference model state: boot pending, buffered redirect.
  bit          m_boot = 1'b1;
  bit          m_pend = 1'b0;
  logic [63:0] m_paddr = '0;

  // Expected outputs for the current cycle.
  logic [63:0] e_pc;
  bit          e_pc_chk, e_stall, e_fetch, e_ifid, e_idex, e_trap;

  pc_sequencer dut (
    .clk_i(clk), .rst_ni(rst_n), .pc_current_i(pc_cur),
    .hazard_stall_i(hs), .imem_ready_i(rdy), .br_taken_i(bt), .br_target_i(tgt),
    .pc_next_o(pc_next), .pc_stall_o(pc_stall), .fetch_req_o(fetch_req),
    .if_id_flush_o(f_ifid), .id_ex_flush_o(f_idex), .misalign_trap_o(trap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Where a redirect address actually lands, and whether it traps.
  task automatic land(input logic [63:0] a);
    e_pc     = a;
    e_pc_chk = 1'b1;
    e_trap   = 1'b0;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    if (a[1:0] != 2'b00) begin
      e_pc   = TRAP;
      e_trap = 1'b1;
    end
`endif
  endtask

  task automatic model_outputs();
    e_pc = pc_cur; e_pc_chk = 1'b1; e_stall = 1'b1; e_fetch = 1'b1;
    e_ifid = 1'b0; e_idex = 1'b0; e_trap = 1'b0;
    if (!rst_n) begin
      e_pc = RV; e_stall = 1'b0; e_fetch = 1'b0;
    end else if (m_boot) begin
      e_pc = RV; e_stall = 1'b0; e_fetch = 1'b0; e_ifid = 1'b1; e_idex = 1'b1;
    end else if (m_pend) begin
      e_ifid = 1'b1;
      if (rdy) begin
        e_stall = 1'b0;
        land(bt ? tgt : m_paddr);
      end else begin
        e_pc_chk = 1'b0;
      end
    end else if (bt) begin
      e_ifid = 1'b1; e_idex = 1'b1;
      if (rdy) begin
        e_stall = 1'b0;
        land(tgt);
      end else begin
        e_pc_chk = 1'b0;
      end
    end else if (!(hs || !rdy)) begin
      e_stall = 1'b0;
      e_pc    = pc_cur + 64'd4;
    end
  endtask

  task automatic model_clock();
    if (!rst_n) begin
      m_boot = 1'b1; m_pend = 1'b0; pc_cur = RV;
    end else begin
      if (!e_stall) pc_cur = e_pc;
      if (m_boot) begin
        m_boot = 1'b0;
      end else if (bt && !rdy) begin
        m_pend = 1'b1; m_paddr = tgt;
      end else if (rdy) begin
        m_pend = 1'b0;
      end
    end
  endtask

  // One clock: drive inputs after the falling edge, check, then advance the model at the rising edge.
  task automatic cycle(input bit r, input bit h, input bit rd, input bit b, input logic [63:0] t);
    @(negedge clk);
    rst_n = r; hs = h; rdy = rd; bt = b; tgt = t;
    #1;
    model_outputs();
    if (e_pc_chk) chk("pc_next", pc_next, e_pc);
    chk("pc_stall", {63'd0, pc_stall}, {63'd0, e_stall});
    chk("fetch_req", {63'd0, fetch_req}, {63'd0, e_fetch});
    chk("if_id_flush", {63'd0, f_ifid}, {63'd0, e_ifid});
    chk("id_ex_flush", {63'd0, f_idex}, {63'd0, e_idex});
    chk("misalign_trap", {63'd0, trap}, {63'd0, e_trap});
    @(posedge clk);
    model_clock();
  endtask

  initial begin
    // Reset held, then boot and sequential fetch 4, 8, 12.
    cycle(0, 0, 1, 0, '0);
    cycle(0, 0, 1, 0, '0);
    cycle(1, 0, 1, 0, '0);
    cycle(1, 0, 1, 0, '0);
    cycle(1, 0, 1, 0, '0);
    cycle(1, 0, 1, 0, '0);
    // Address wrap at the top of the space.
    pc_cur = 64'hFFFF_FFFF_FFFF_FFFC;
    cycle(1, 0, 1, 0, '0);
    // Hazard hold and imem-not-ready hold.
    cycle(1, 1, 1, 0, '0);
    cycle(1, 0, 0, 0, '0);
    // Branch overrides hazard stall.
    cycle(1, 1, 1, 1, 64'h2000);
    // Buffered redirect: three not-ready cycles, then lands.
    cycle(1, 0, 0, 1, 64'h3000);
    cycle(1, 0, 0, 0, '0);
    cycle(1, 0, 0, 0, '0);
    cycle(1, 0, 1, 0, '0);
    cycle(1, 0, 1, 0, '0);
    // Youngest redirect wins; hazard ignored while pending.
    cycle(1, 0, 0, 1, 64'h4000);
    cycle(1, 0, 0, 1, 64'h5000);
    cycle(1, 1, 1, 0, '0);
    // Pending exit with a fresh redirect in the same cycle.
    cycle(1, 0, 0, 1, 64'h6000);
    cycle(1, 0, 1, 1, 64'h7000);
    // Misaligned target, direct and buffered.
    cycle(1, 0, 1, 1, 64'h1002);
    cycle(1, 0, 1, 0, '0);
    cycle(1, 0, 0, 1, 64'h2006);
    cycle(1, 0, 1, 0, '0);
    // Reset while a redirect is pending discards it.
    cycle(1, 0, 0, 1, 64'h3000);
    cycle(1, 0, 0, 0, '0);
    cycle(0, 0, 1, 0, '0);
    cycle(1, 0, 1, 0, '0);
    cycle(1, 0, 1, 0, '0);
    cycle(1, 0, 1, 0, '0);
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [63:0] t;
      t = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) t[1:0] = 2'b00;
      cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 6) == 0), t);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch-stage controller that drives the program counter register's next-address input and stall input.
- Chooses between sequential fetch, branch/jump redirect, and hold; also drives pipeline flushes.
- Sequences start-up after reset and buffers a redirect that arrives while instruction memory is not ready.
- Sits between the PC register, instruction memory handshake, hazard unit and EX-stage branch resolution.

Parameters:
XLEN, 64, address width of PC and targets
RESET_VECTOR, 64'h0, first fetch address after reset
INSTR_BYTES, 4, sequential increment
TRAP_VECTOR, 64'h100, misalignment trap target (used only with optional feature)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous active-low reset; asserting it (low) clears all state immediately
pc_current  input  XLEN  current PC register output
hazard_stall  input  1  load-use stall from hazard unit
imem_ready  input  1  instruction memory accepts fetch this cycle
br_taken  input  1  EX stage resolved a taken branch/jump (single-cycle pulse)
br_target  input  XLEN  redirect target, valid with br_taken
pc_next  output  XLEN  to PC register data input
pc_stall  output  1  to PC register stall input (1 = hold)
fetch_req  output  1  fetch request to instruction memory
if_id_flush  output  1  squash IF/ID register
id_ex_flush  output  1  squash ID/EX register
misalign_trap  output  1  trap pulse (optional feature only; tied 0 otherwise)

Behaviour:
- Outputs are combinational from state and inputs. The only registers are state, pend_target[XLEN] and a misalign flag.
- States: BOOT, RUN, PEND.
- Reset (low, asynchronous):
  - state=BOOT, pend_target=0.
  - Outputs while reset is held: pc_next=RESET_VECTOR, pc_stall=0, fetch_req=0, both flushes 0, misalign_trap=0.
  - Reset asserted mid-operation discards any pending redirect.
- BOOT:
  - One cycle after reset deasserts.
  - pc_next=RESET_VECTOR, pc_stall=0 (loads vector), fetch_req=0, flushes=1.
  - Next state: RUN.
- RUN, priority order:
  1. br_taken & imem_ready: pc_next=br_target, pc_stall=0, if_id_flush=1, id_ex_flush=1. Overrides hazard_stall. Stay in RUN.
  2. br_taken & !imem_ready: pend_target<=br_target, pc_stall=1, if_id_flush=1, id_ex_flush=1. Next state: PEND.
  3. hazard_stall | !imem_ready: pc_stall=1, pc_next=pc_current, no flush.
  4. Otherwise: pc_next=pc_current+INSTR_BYTES, modulo 2^XLEN (wraps to 0, no error); pc_stall=0.
  - fetch_req=1 in RUN.
- PEND:
  - fetch_req=1, pc_stall=1, if_id_flush=1 every cycle, id_ex_flush=0.
  - When imem_ready=1: pc_next=pend_target, pc_stall=0. Next state: RUN.
  - A new br_taken in PEND overwrites pend_target (youngest redirect wins).
  - If imem_ready is also 1 in that cycle, br_target is used directly.
  - hazard_stall is ignored in PEND.
- Redirect latency: 0 cycles when imem is ready. Otherwise the redirect completes in the first cycle imem_ready is seen.

Optional Feature:
- Macro: PC_SEQ_MISALIGN_TRAP_EN.
- Defined:
  - Any redirect with br_target[1:0]!=0 uses TRAP_VECTOR instead of br_target.
  - misalign_trap pulses 1 in the cycle the redirect is applied (RUN or PEND exit).
  - The trap decision is registered with pend_target when the redirect is buffered.
- Undefined:
  - Targets are used unmodified and misalign_trap is tied 0.

Test Plan:
- Release reset, imem_ready=1 -> BOOT cycle: pc_next=0, flushes=1, fetch_req=0. Following cycles: pc_next=4, 8, 12.
- pc_current=64'hFFFF_FFFF_FFFF_FFFC, no stall -> pc_next=64'h0.
- hazard_stall=1 and br_taken=1 with target 64'h2000, same cycle -> pc_next=64'h2000, pc_stall=0, both flushes 1.
- br_taken target 64'h3000 with imem_ready=0 for 3 cycles -> pc_stall=1 for 3 cycles, if_id_flush=1. Cycle 4 with ready=1 -> pc_next=64'h3000.
- In PEND holding 64'h3000, pull reset low -> immediately pc_next=RESET_VECTOR, fetch_req=0. After release -> BOOT, 64'h3000 never issued.
- With PC_SEQ_MISALIGN_TRAP_EN: br_target=64'h1002 -> pc_next=64'h100, misalign_trap=1 for one cycle. Without the macro -> pc_next=64'h1002, trap=0.
